memory_burst: RTL

Parametrised single-port synchronous memory, successor to the basic valid/wrbar memory. Adds byte write strobes, burst transfers with address auto-increment and wrap, a configurable read pipeline, and an optional post-reset clear sweep. Sits between a bus master and local storage wherever the plain memory no longer meets throughput needs.

---
 rtl/memory_burst.sv | 127 ++++++++++++
 1 files changed

// File: rtl/memory_burst.sv
// memory_burst: single-port synchronous memory with byte strobes, wrapping bursts,
// a READ_LAT-deep read pipeline and an optional post-reset clear sweep.
module memory_burst #(
   parameter int unsigned WIDTH        = 32,
   parameter int unsigned ADDR         = 8,
   parameter int unsigned DEPTH        = 256,
   parameter int unsigned READ_LAT     = 2,
   parameter int unsigned BLEN_W       = 4,
   parameter int unsigned CLEAR_ON_RST = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               valid,
   output logic               ready,
   input  logic               wrbar,
   input  logic [ADDR-1:0]    addr,
   input  logic [BLEN_W-1:0]  blen,
   input  logic [WIDTH-1:0]   wdata,
   input  logic [WIDTH/8-1:0] wstrb,
   output logic [WIDTH-1:0]   rdata,
   output logic               rvalid,
   output logic               busy
);
   localparam int unsigned NBYTE = WIDTH / 8;
   localparam int unsigned PW    = READ_LAT * WIDTH;

   typedef enum logic [1:0] {INIT, IDLE, WBURST, RBURST} state_t;

   state_t                           state, state_n;
   logic [BLEN_W-1:0]                cnt, cnt_n;
   logic [ADDR-1:0]                  acnt, acnt_n;
   logic [READ_LAT-1:0]              vpipe, vpipe_n;
   logic [READ_LAT-1:0][WIDTH-1:0]   dpipe;
   logic [WIDTH-1:0]                 mem [DEPTH];

   logic                             xfer_c, wen_c, ren_c, clr_c;
   logic [ADDR-1:0]                  maddr_c;
   logic [WIDTH-1:0]                 rd0_c;

   // Next-state, counter and memory-port decode
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      acnt_n  = acnt;
      xfer_c  = valid && ready;
      wen_c   = 1'b0;
      ren_c   = 1'b0;
      clr_c   = 1'b0;
      maddr_c = acnt;
      case (state)
         INIT: begin
            clr_c  = 1'b1;
            acnt_n = acnt + ADDR'(1);
            if (acnt == ADDR'(DEPTH - 1)) state_n = IDLE;
         end
         IDLE: begin
            if (xfer_c) begin
               maddr_c = addr;
               wen_c   = wrbar;
               ren_c   = !wrbar;
               cnt_n   = blen;
               acnt_n  = addr + ADDR'(1);
               if (blen != '0) state_n = wrbar ? WBURST : RBURST;
            end
         end
         WBURST: begin
            if (valid) begin
               wen_c  = 1'b1;
               acnt_n = acnt + ADDR'(1);
               cnt_n  = cnt - BLEN_W'(1);
               if (cnt == BLEN_W'(1)) state_n = IDLE;
            end
         end
         RBURST: begin
            ren_c  = 1'b1;
            acnt_n = acnt + ADDR'(1);
            cnt_n  = cnt - BLEN_W'(1);
            if (cnt == BLEN_W'(1)) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      // Reset aborts any access that would otherwise land on this edge
      if (!rst) begin
         wen_c = 1'b0;
         ren_c = 1'b0;
         clr_c = 1'b0;
      end
      vpipe_n = READ_LAT'({vpipe, ren_c});
      rd0_c   = ren_c ? mem[maddr_c] : dpipe[0];
   end

   // Control state, read pipeline and registered status outputs
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= (CLEAR_ON_RST != 0) ? INIT : IDLE;
         cnt   <= '0;
         acnt  <= '0;
         vpipe <= '0;
         dpipe <= '0;
         ready <= (CLEAR_ON_RST == 0);
         busy  <= (CLEAR_ON_RST != 0);
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         acnt  <= acnt_n;
         vpipe <= vpipe_n;
         dpipe <= PW'({dpipe, rd0_c});
         ready <= (state_n == IDLE) || (state_n == WBURST);
         busy  <= (state_n != IDLE) || (vpipe_n != '0);
      end
   end

   // Storage: clear sweep or strobed write, never both
   always_ff @(posedge clk) begin
      if (clr_c) begin
         mem[maddr_c] <= '0;
      end else if (wen_c) begin
         for (int b = 0; b < NBYTE; b++) begin
            if (wstrb[b]) mem[maddr_c][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   assign rdata  = dpipe[READ_LAT-1];
   assign rvalid = vpipe[READ_LAT-1];

endmodule
